// File: rtl/imem_pkg.sv
// imem_pkg: types and constants shared by the instruction-memory arbiter
// and its helpers.
//   arb_state_t : arbiter FSM state (ARB = normal priority arbitration,
//                 LOCKED = loader owns the memory port exclusively)
//   owner_t     : which requester a pending read return belongs to
//   STATS_W     : width of the optional per-requester grant counters
//                 (the counters exist only when IMEM_ARB_STATS_EN is defined)
package imem_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_LOAD  = 1'b1
    } owner_t;

    localparam int STATS_W = 16;

endpackage

// File: rtl/imem_addr_split.sv
// imem_addr_split: splits a flat word address into the row (X) and column
// (Y) halves used by the X/Y-addressed memory macro. Both halves are
// zero-extended back to the full address width so any memory client can
// drive the macro ports directly.
// Parameters:
//   ADDR_BITS : flat address width, must be even
// Ports:
//   addr : in  flat word address
//   x    : out row    = addr[ADDR_BITS-1:ADDR_BITS/2], zero-extended
//   y    : out column = addr[ADDR_BITS/2-1:0],         zero-extended
module imem_addr_split
    import imem_pkg::*;
#(
    parameter int ADDR_BITS = 8
) (
    input  logic [ADDR_BITS-1:0] addr,
    output logic [ADDR_BITS-1:0] x,
    output logic [ADDR_BITS-1:0] y
);

    localparam int HALF = ADDR_BITS / 2;

    assign x = {{(ADDR_BITS - HALF){1'b0}}, addr[ADDR_BITS-1:HALF]};
    assign y = {{(ADDR_BITS - HALF){1'b0}}, addr[HALF-1:0]};

endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the single instruction-memory port between the fetch
// requester (read-only) and the loader/debug requester (read/write).
//
// Handshake: a requester raises req with its address/data and holds them
// until gnt is seen high; the request is accepted on the rising edge that
// closes a cycle with gnt high. Grants are combinational and at most one is
// given per cycle. Read data returns exactly one cycle after the grant with
// a single-cycle rvalid strobe; rdata is 0 whenever rvalid is 0. Loader
// writes produce no response.
//
// Optional feature: define IMEM_ARB_STATS_EN to add the saturating grant
// counters f_count / l_count. Without it those outputs do not exist and
// arbitration is identical.
//
// Ports:
//   Clock, Reset        : clock (rising edge), async active-high reset
//   f_req/f_addr        : fetch read request and word address
//   f_gnt               : fetch request accepted this cycle
//   f_rvalid/f_rdata    : fetch read return
//   l_req/l_we/l_lock   : loader request, write flag, exclusive-lock request
//   l_addr/l_wdata      : loader word address and write data
//   l_gnt               : loader request accepted this cycle
//   l_rvalid/l_rdata    : loader read return
//   WriteEnable/ReadEnable, X_addr/Y_addr, Data_in : memory macro controls
//   Data_out            : memory read data (registered inside the macro)
//   arb_state           : current FSM state, for observation
//   f_count/l_count     : grant counters (IMEM_ARB_STATS_EN only)
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int ADDR_BITS    = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  f_req,
    input  logic [ADDR_BITS-1:0]  f_addr,
    output logic                  f_gnt,
    output logic                  f_rvalid,
    output logic [DATA_WIDTH-1:0] f_rdata,
    input  logic                  l_req,
    input  logic                  l_we,
    input  logic                  l_lock,
    input  logic [ADDR_BITS-1:0]  l_addr,
    input  logic [DATA_WIDTH-1:0] l_wdata,
    output logic                  l_gnt,
    output logic                  l_rvalid,
    output logic [DATA_WIDTH-1:0] l_rdata,
    output logic                  WriteEnable,
    output logic                  ReadEnable,
    output logic [ADDR_BITS-1:0]  X_addr,
    output logic [ADDR_BITS-1:0]  Y_addr,
    output logic [DATA_WIDTH-1:0] Data_in,
    input  logic [DATA_WIDTH-1:0] Data_out,
    output arb_state_t            arb_state
`ifdef IMEM_ARB_STATS_EN
    ,
    output logic [STATS_W-1:0]    f_count,
    output logic [STATS_W-1:0]    l_count
`endif
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_t           state, next_state;
    logic [CNT_W-1:0]     starve_cnt, starve_next;
    logic                 starved;
    logic                 rd_pending;
    owner_t               rd_owner;
    logic [ADDR_BITS-1:0] sel_addr;

    assign starved   = (starve_cnt == CNT_MAX);
    assign arb_state = state;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= ARB;
            starve_cnt <= '0;
        end else begin
            state      <= next_state;
            starve_cnt <= starve_next;
        end
    end

    // ------------------------------------------------------------------
    // Grant / next-state logic. Everything is forced idle while Reset is
    // high so no strobe reaches the memory during reset.
    // ------------------------------------------------------------------
    always_comb begin
        next_state  = state;
        starve_next = starve_cnt;
        f_gnt       = 1'b0;
        l_gnt       = 1'b0;
        if (!Reset) begin
            case (state)
                ARB: begin
                    // Fetch has priority until the loader has been denied
                    // STARVE_LIMIT cycles in a row.
                    if (l_req && (starved || !f_req)) begin
                        l_gnt = 1'b1;
                    end else if (f_req) begin
                        f_gnt = 1'b1;
                    end
                    // A lock only takes hold once the loader actually wins.
                    if (l_gnt && l_lock) begin
                        next_state = LOCKED;
                    end
                    if (!l_req || l_gnt) begin
                        starve_next = '0;
                    end else if (!starved) begin
                        starve_next = starve_cnt + CNT_W'(1);
                    end
                end
                LOCKED: begin
                    l_gnt       = l_req;
                    starve_next = '0;
                    if (!l_lock) begin
                        next_state = ARB;
                    end
                end
                default: begin
                    next_state = ARB;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Memory-side controls, driven by the winning request only
    // ------------------------------------------------------------------
    always_comb begin
        sel_addr = '0;
        if (l_gnt) begin
            sel_addr = l_addr;
        end else if (f_gnt) begin
            sel_addr = f_addr;
        end
    end

    assign ReadEnable  = f_gnt | (l_gnt & ~l_we);
    assign WriteEnable = l_gnt & l_we;
    assign Data_in     = WriteEnable ? l_wdata : '0;

    imem_addr_split #(
        .ADDR_BITS(ADDR_BITS)
    ) u_addr_split (
        .addr(sel_addr),
        .x   (X_addr),
        .y   (Y_addr)
    );

    // ------------------------------------------------------------------
    // Read-return tag. The async reset clears rd_pending, so a read granted
    // just as Reset rises never produces a response.
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rd_pending <= 1'b0;
            rd_owner   <= OWN_FETCH;
        end else begin
            rd_pending <= ReadEnable;
            rd_owner   <= l_gnt ? OWN_LOAD : OWN_FETCH;
        end
    end

    assign f_rvalid = rd_pending && (rd_owner == OWN_FETCH);
    assign l_rvalid = rd_pending && (rd_owner == OWN_LOAD);
    // Gate data with rvalid so an undriven macro output never leaks out.
    assign f_rdata  = f_rvalid ? Data_out : '0;
    assign l_rdata  = l_rvalid ? Data_out : '0;

`ifdef IMEM_ARB_STATS_EN
    // ------------------------------------------------------------------
    // Saturating grant counters
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            f_count <= '0;
            l_count <= '0;
        end else begin
            if (f_gnt && (f_count != {STATS_W{1'b1}})) begin
                f_count <= f_count + STATS_W'(1);
            end
            if (l_gnt && (l_count != {STATS_W{1'b1}})) begin
                l_count <= l_count + STATS_W'(1);
            end
        end
    end
`endif

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Two-port arbiter and sequencer in front of the X/Y-addressed instruction memory. Shares the single memory port between the instruction-fetch requester (read-only) and the program loader/debug requester (read/write), splits flat word addresses into row/column halves, and returns read data with a one-cycle valid strobe. Sits between the fetch stage, the loader, and the instruction memory macro.

## Interface
- ADDR_BITS, 8, flat word-address width; must be even
- DATA_WIDTH, 32, instruction word width
- STARVE_LIMIT, 4, consecutive denied loader cycles before the loader overrides fetch priority; ≥1

- Clock  in  1  single clock, rising edge
- Reset  in  1  asynchronous, active-high
- f_req  in  1  fetch read request
- f_addr  in  ADDR_BITS  fetch word address
- f_gnt  out  1  fetch request accepted this cycle
- f_rvalid  out  1  f_rdata valid
- f_rdata  out  DATA_WIDTH  fetch read data
- l_req  in  1  loader request
- l_we  in  1  loader request is a write
- l_lock  in  1  loader requests exclusive ownership
- l_addr  in  ADDR_BITS  loader word address
- l_wdata  in  DATA_WIDTH  loader write data
- l_gnt  out  1  loader request accepted this cycle
- l_rvalid  out  1  l_rdata valid
- l_rdata  out  DATA_WIDTH  loader read data
- WriteEnable, ReadEnable  out  1  memory strobes
- X_addr, Y_addr  out  ADDR_BITS  memory row/column
- Data_in  out  DATA_WIDTH  memory write data
- Data_out  in  DATA_WIDTH  memory read data (registered in the memory)

## Operation
- At most one grant per cycle; request accepted on the rising edge closing a cycle with gnt high. Requester holds req/addr/data until gnt.
- Memory controls are combinational from the winning request: X_addr = zero-extended addr[ADDR_BITS-1:ADDR_BITS/2], Y_addr = zero-extended addr[ADDR_BITS/2-1:0]; ReadEnable = granted read; WriteEnable = granted loader write; Data_in = l_wdata when writing, else 0.
- Priority (state ARB): fetch wins, unless starve_cnt == STARVE_LIMIT, then loader wins.
- starve_cnt: +1 each cycle l_req high and l_gnt low (saturates at STARVE_LIMIT); cleared on l_gnt or l_req low.
- FSM states: ARB, LOCKED. ARB→LOCKED on edge where l_gnt && l_lock. LOCKED: f_gnt = 0, l_gnt = l_req, starve_cnt held 0. LOCKED→ARB on edge where l_lock is low.
- Read return: registered tag {rd_pending, rd_owner} captured at grant; next cycle the owner's rvalid = 1 and rdata = Data_out; non-owner rdata = 0. rdata = 0 whenever rvalid = 0 (memory X never propagated).
- Loader writes produce no response. Write in cycle N followed by read of same address in N+1 returns new data.

## Timing
- Grant: combinational, same cycle as req.
- Read latency: rvalid exactly 1 cycle after gnt; back-to-back reads every cycle sustained.
- Reset (any time, async): state ARB, starve_cnt 0, rd_pending 0; all outputs 0 while Reset high (including gnt and memory strobes). A read granted the cycle Reset asserts never produces rvalid.
- l_lock with l_req low: no effect. l_lock raised while fetch holds priority: takes effect only on the loader's first grant.

## Configuration
- IMEM_ARB_STATS_EN defined: adds outputs f_count, l_count (16-bit, saturating at 0xFFFF, cleared by Reset) counting grants per requester.
- Undefined: outputs and counters absent; arbitration unchanged.

## Structure
- Shared package imem_pkg: arb_state_t enum {ARB, LOCKED}, owner_t enum {OWN_FETCH, OWN_LOAD}, STATS counter width constant.
- One sub-module: imem_addr_split (flat address → X/Y halves, zero-extended), reusable by other memory clients.

## Test plan
- Fetch-only: f_req reads 0x00..0x03 each cycle → f_gnt every cycle, f_rvalid one cycle later with preloaded words, X/Y = {0,0},{0,1},{0,2},{0,3}.
- Contention, STARVE_LIMIT=4: f_req and l_req read held high → f_gnt cycles 0–3, l_gnt cycle 4, f_gnt cycle 5; l_rvalid in cycle 5 only.
- Lock: loader writes 0xDEADBEEF to 0x25 with l_lock=1 while f_req high → LOCKED, f_gnt 0 until l_lock drops; X_addr=2, Y_addr=5; fetch read of 0x25 afterwards returns 0xDEADBEEF.
- Write-then-read: loader write 0x12345678 to 0x11 cycle N, loader read 0x11 cycle N+1 → l_rvalid N+2, l_rdata 0x12345678.
- Reset mid-read: assert Reset the cycle after f_gnt → f_rvalid 0, f_rdata 0, all strobes 0; after release fetch granted normally.
- With IMEM_ARB_STATS_EN: 10 fetch and 3 loader grants → f_count=10, l_count=3; Reset clears both.
